cache_line_fill_unit: RTL and testbench

Refill engine that sits directly upstream of the cache data RAM's two write ports (A and B). It accepts a line-fill request and issues one read request to the next memory level. It receives the line as a critical-word-first, wrap-around beat stream, pairs consecutive beats, and writes two words per cycle into the RAM. It also forwards the critical word to the core and signals completion when the whole line is resident.

---
 rtl/cache_line_fill_unit.sv | 182 ++++++++++++++++++
 tb/tb_cache_line_fill_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill_unit.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_fill_unit
// Brief    : Line-refill engine. Issues one critical-word-first read, pairs
//            wrap-around beats and writes two words per cycle into the data RAM.
// Revision : 1.0  initial release
// ============================================================================
module cache_line_fill_unit #(
  parameter int ADDRESS_SPACE = 12,
  parameter int DATA_SIZE     = 32,
  parameter int LINE_WORDS    = 8,
  parameter int LINE_BITS     = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fill_req,
  input  logic [ADDRESS_SPACE-LINE_BITS-1:0] fill_line_addr,
  input  logic [LINE_BITS-1:0]            fill_crit_word,
  output logic                            fill_busy,
  output logic                            fill_done,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [ADDRESS_SPACE-1:0]        mem_req_addr,
  input  logic                            mem_rsp_valid,
  output logic                            mem_rsp_ready,
  input  logic [DATA_SIZE-1:0]            mem_rsp_data,
  output logic                            crit_valid,
  output logic [DATA_SIZE-1:0]            crit_data,
  output logic [DATA_SIZE-1:0]            ram_data_a,
  output logic [DATA_SIZE-1:0]            ram_data_b,
  output logic [ADDRESS_SPACE-1:0]        ram_addr_a,
  output logic [ADDRESS_SPACE-1:0]        ram_addr_b,
  output logic                            ram_we_a,
  output logic                            ram_we_b
);

  localparam int LINE_ADDR_W = ADDRESS_SPACE - LINE_BITS;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_REQ   = 3'd1;
  localparam logic [2:0] c_FILL  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [LINE_BITS-1:0] c_LAST_BEAT = LINE_BITS'(LINE_WORDS - 1);

  logic [2:0]               r_state;
  logic [2:0]               w_next_state;
  logic [LINE_ADDR_W-1:0]   r_line;
  logic [LINE_BITS-1:0]     r_crit;
  logic [LINE_BITS-1:0]     r_cnt;
  logic [DATA_SIZE-1:0]     r_hold_data;
  logic [ADDRESS_SPACE-1:0] r_hold_addr;
  logic [DATA_SIZE-1:0]     r_ram_data_a;
  logic [DATA_SIZE-1:0]     r_ram_data_b;
  logic [ADDRESS_SPACE-1:0] r_ram_addr_a;
  logic [ADDRESS_SPACE-1:0] r_ram_addr_b;
  logic                     r_ram_we;
  logic                     r_crit_valid;
  logic [DATA_SIZE-1:0]     r_crit_data;

  logic                     w_accept_req;
  logic                     w_beat;
  logic                     w_last_beat;
  logic [LINE_BITS-1:0]     w_beat_off;
  logic [ADDRESS_SPACE-1:0] w_beat_addr;

  assign w_accept_req = (r_state == c_IDLE) && fill_req;
  assign w_beat       = (r_state == c_FILL) && mem_rsp_valid;
  assign w_last_beat  = (r_cnt == c_LAST_BEAT);
  // Offset arithmetic is LINE_BITS wide so the beat address wraps inside the line.
  assign w_beat_off   = r_crit + r_cnt;
  assign w_beat_addr  = {r_line, w_beat_off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (fill_req) w_next_state = c_REQ;
      c_REQ:   if (mem_req_ready) w_next_state = c_FILL;
      c_FILL:  if (w_beat && w_last_beat) w_next_state = c_DRAIN;
      c_DRAIN: w_next_state = c_DONE;
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    fill_busy     = 1'b0;
    fill_done     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_rsp_ready = 1'b0;
    case (r_state)
      c_REQ: begin
        fill_busy     = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_line, r_crit};
      end
      c_FILL: begin
        fill_busy     = 1'b1;
        mem_rsp_ready = 1'b1;
      end
      c_DRAIN: fill_busy = 1'b1;
      c_DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_crit <= '0;
      r_cnt  <= '0;
    end else if (w_accept_req) begin
      r_line <= fill_line_addr;
      r_crit <= fill_crit_word;
      r_cnt  <= '0;
    end else if (w_beat) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Even beats park in the holding register; each odd beat releases a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data  <= '0;
      r_hold_addr  <= '0;
      r_ram_data_a <= '0;
      r_ram_data_b <= '0;
      r_ram_addr_a <= '0;
      r_ram_addr_b <= '0;
      r_ram_we     <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_beat && !r_cnt[0]) begin
        r_hold_data <= mem_rsp_data;
        r_hold_addr <= w_beat_addr;
      end
      if (w_beat && r_cnt[0]) begin
        r_ram_we     <= 1'b1;
        r_ram_data_a <= r_hold_data;
        r_ram_addr_a <= r_hold_addr;
        r_ram_data_b <= mem_rsp_data;
        r_ram_addr_b <= w_beat_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
    end else begin
      r_crit_valid <= w_beat && (r_cnt == '0);
      if (w_beat && (r_cnt == '0)) begin
        r_crit_data <= mem_rsp_data;
      end
    end
  end

  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;
  assign ram_data_a = r_ram_data_a;
  assign ram_data_b = r_ram_data_b;
  assign ram_addr_a = r_ram_addr_a;
  assign ram_addr_b = r_ram_addr_b;
  assign ram_we_a   = r_ram_we;
  assign ram_we_b   = r_ram_we;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_fill_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_fill_unit
// Brief    : Directed table-driven bench for cache_line_fill_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_line_fill_unit;

  logic        clk;
  logic        rst_n;
  logic        fill_req;
  logic [8:0]  fill_line_addr;
  logic [2:0]  fill_crit_word;
  logic        fill_busy;
  logic        fill_done;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [11:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_data;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic [31:0] ram_data_a;
  logic [31:0] ram_data_b;
  logic [11:0] ram_addr_a;
  logic [11:0] ram_addr_b;
  logic        ram_we_a;
  logic        ram_we_b;

  cache_line_fill_unit #(
    .ADDRESS_SPACE(12), .DATA_SIZE(32), .LINE_WORDS(8), .LINE_BITS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_req(fill_req), .fill_line_addr(fill_line_addr), .fill_crit_word(fill_crit_word),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] aa;
    logic [11:0] ab;
    logic [31:0] da;
    logic [31:0] db;
  } pair_t;

  typedef struct {
    logic [8:0]        line;
    logic [2:0]        crit;
    logic [15:0]       pat;
    int                req_delay;
    int                busy_at;
    int                abort_at;
    logic [11:0]       exp_req;
    logic [3:0][11:0]  exp_a;
    logic [3:0][11:0]  exp_b;
  } vec_t;

  // RAM model standing in for the data RAM; ports C/D read-back is a direct lookup.
  logic [31:0] ram_model [0:4095];
  pair_t       wr_log [$];

  always @(posedge clk) begin
    if (ram_we_a) ram_model[ram_addr_a] <= ram_data_a;
    if (ram_we_b) ram_model[ram_addr_b] <= ram_data_b;
    if (ram_we_a) wr_log.push_back('{aa: ram_addr_a, ab: ram_addr_b, da: ram_data_a, db: ram_data_b});
  end

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_word(input logic [8:0] line, input int k);
    logic [2:0] kk;
    kk = 3'(k);
    return {8'hC5, 7'b0, line, 5'b0, kk};
  endfunction

  function automatic logic [3:0][11:0] pk4(input logic [11:0] a0, input logic [11:0] a1,
                                           input logic [11:0] a2, input logic [11:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, fill_busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, fill_done}, 32'd0);
    chk({tag, "_reqv"}, {31'b0, mem_req_valid}, 32'd0);
    chk({tag, "_reqa"}, {20'b0, mem_req_addr}, 32'd0);
    chk({tag, "_rspr"}, {31'b0, mem_rsp_ready}, 32'd0);
    chk({tag, "_critv"}, {31'b0, crit_valid}, 32'd0);
    chk({tag, "_critd"}, crit_data, 32'd0);
    chk({tag, "_we"}, {30'b0, ram_we_a, ram_we_b}, 32'd0);
    chk({tag, "_ramd"}, ram_data_a | ram_data_b, 32'd0);
    chk({tag, "_rama"}, {20'b0, ram_addr_a | ram_addr_b}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int base;
    int k;
    int c;
    logic exp_we;
    logic crit_pend;
    logic [2:0] off;
    base = wr_log.size();

    @(negedge clk);
    fill_req       = 1'b1;
    fill_line_addr = v.line;
    fill_crit_word = v.crit;
    @(negedge clk);
    fill_req = 1'b0;
    chk($sformatf("v%0d_req_busy", id), {31'b0, fill_busy}, 32'd1);
    chk($sformatf("v%0d_req_valid", id), {31'b0, mem_req_valid}, 32'd1);
    chk($sformatf("v%0d_req_addr", id), {20'b0, mem_req_addr}, {20'b0, v.exp_req});

    // Request backpressure: beats offered early must not be taken.
    for (int d = 0; d < v.req_delay; d++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hBAD0_0000 | d;
      @(negedge clk);
      chk($sformatf("v%0d_bp_valid", id), {31'b0, mem_req_valid}, 32'd1);
      chk($sformatf("v%0d_bp_addr", id), {20'b0, mem_req_addr}, {20'b0, v.exp_req});
      chk($sformatf("v%0d_bp_rspr", id), {31'b0, mem_rsp_ready}, 32'd0);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk($sformatf("v%0d_fill_rspr", id), {31'b0, mem_rsp_ready}, 32'd1);

    k = 0;
    c = 0;
    while (k < 8 && c < 64) begin
      if (k == v.abort_at) break;
      fill_req = (c == v.busy_at);
      fill_line_addr = v.line ^ 9'h001;
      if (v.pat[c % 16]) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = beat_word(v.line, k);
        exp_we        = k[0];
        crit_pend     = (k == 0);
        k++;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0BB0_0000 | c;
        exp_we        = 1'b0;
        crit_pend     = 1'b0;
      end
      c++;
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_we", id, c), {30'b0, ram_we_a, ram_we_b}, {30'b0, exp_we, exp_we});
      chk($sformatf("v%0d_c%0d_critv", id, c), {31'b0, crit_valid}, {31'b0, crit_pend});
      if (crit_pend) chk($sformatf("v%0d_critd", id), crit_data, beat_word(v.line, 0));
    end
    fill_req = 1'b0;
    mem_rsp_valid = 1'b0;

    if (v.abort_at < 8) begin
      chk($sformatf("v%0d_abort_k", id), k, v.abort_at);
      rst_n = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = beat_word(v.line, k);
      #1;
      check_all_zero($sformatf("v%0d_midrst", id));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
        mem_rsp_data = beat_word(v.line, k + 1 + j);
        @(negedge clk);
        chk($sformatf("v%0d_post_rst_busy%0d", id, j), {31'b0, fill_busy}, 32'd0);
        chk($sformatf("v%0d_post_rst_act%0d", id, j),
            {28'b0, mem_rsp_ready, ram_we_a, crit_valid, fill_done}, 32'd0);
      end
      mem_rsp_valid = 1'b0;
      return;
    end

    if (k < 8) chk($sformatf("v%0d_beat_timeout", id), k, 8);
    chk($sformatf("v%0d_drain_done", id), {31'b0, fill_done}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done", id), {31'b0, fill_done}, 32'd1);
    chk($sformatf("v%0d_done_we", id), {31'b0, ram_we_a}, 32'd0);
    chk($sformatf("v%0d_npairs", id), wr_log.size() - base, 4);
    if (wr_log.size() - base == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("v%0d_p%0d_aa", id, j), {20'b0, wr_log[base+j].aa}, {20'b0, v.exp_a[j]});
        chk($sformatf("v%0d_p%0d_ab", id, j), {20'b0, wr_log[base+j].ab}, {20'b0, v.exp_b[j]});
        chk($sformatf("v%0d_p%0d_da", id, j), wr_log[base+j].da, beat_word(v.line, 2*j));
        chk($sformatf("v%0d_p%0d_db", id, j), wr_log[base+j].db, beat_word(v.line, 2*j+1));
      end
    end
    for (int o = 0; o < 8; o++) begin
      off = 3'(o) - v.crit;
      chk($sformatf("v%0d_ram%0d", id, o), ram_model[{v.line, 3'(o)}], beat_word(v.line, int'(off)));
    end
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", id), {31'b0, fill_busy}, 32'd0);
    chk($sformatf("v%0d_idle_done", id), {31'b0, fill_done}, 32'd0);
    chk($sformatf("v%0d_idle_reqv", id), {31'b0, mem_req_valid}, 32'd0);
    chk($sformatf("v%0d_crit_hold", id), crit_data, beat_word(v.line, 0));
    @(negedge clk);
    chk($sformatf("v%0d_noqueue", id), {31'b0, mem_req_valid}, 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    fill_req = 1'b0;
    fill_line_addr = '0;
    fill_crit_word = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;

    vecs[0] = '{line: 9'h01F, crit: 3'd0, pat: 16'hFFFF, req_delay: 0, busy_at: -1, abort_at: 8,
                exp_req: 12'h0F8, exp_a: pk4(12'h0F8, 12'h0FA, 12'h0FC, 12'h0FE),
                exp_b: pk4(12'h0F9, 12'h0FB, 12'h0FD, 12'h0FF)};
    vecs[1] = '{line: 9'h01F, crit: 3'd5, pat: 16'hFFFF, req_delay: 0, busy_at: -1, abort_at: 8,
                exp_req: 12'h0FD, exp_a: pk4(12'h0FD, 12'h0FF, 12'h0F9, 12'h0FB),
                exp_b: pk4(12'h0FE, 12'h0F8, 12'h0FA, 12'h0FC)};
    vecs[2] = '{line: 9'h01F, crit: 3'd0, pat: 16'b1011_0110_1101_1001, req_delay: 0, busy_at: -1, abort_at: 8,
                exp_req: 12'h0F8, exp_a: pk4(12'h0F8, 12'h0FA, 12'h0FC, 12'h0FE),
                exp_b: pk4(12'h0F9, 12'h0FB, 12'h0FD, 12'h0FF)};
    vecs[3] = '{line: 9'h00A, crit: 3'd3, pat: 16'hFFFF, req_delay: 6, busy_at: -1, abort_at: 8,
                exp_req: 12'h053, exp_a: pk4(12'h053, 12'h055, 12'h057, 12'h051),
                exp_b: pk4(12'h054, 12'h056, 12'h050, 12'h052)};
    vecs[4] = '{line: 9'h030, crit: 3'd6, pat: 16'hFFFF, req_delay: 0, busy_at: 2, abort_at: 8,
                exp_req: 12'h186, exp_a: pk4(12'h186, 12'h180, 12'h182, 12'h184),
                exp_b: pk4(12'h187, 12'h181, 12'h183, 12'h185)};
    vecs[5] = '{line: 9'h005, crit: 3'd0, pat: 16'hFFFF, req_delay: 0, busy_at: -1, abort_at: 4,
                exp_req: 12'h028, exp_a: pk4(12'h028, 12'h02A, 12'h02C, 12'h02E),
                exp_b: pk4(12'h029, 12'h02B, 12'h02D, 12'h02F)};
    vecs[6] = '{line: 9'h002, crit: 3'd1, pat: 16'hFFFF, req_delay: 0, busy_at: -1, abort_at: 8,
                exp_req: 12'h011, exp_a: pk4(12'h011, 12'h013, 12'h015, 12'h017),
                exp_b: pk4(12'h012, 12'h014, 12'h016, 12'h010)};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
